// File: rtl/poly_tobytes.sv
// Serialiser for the NewHope poly_tobytes encoding. It reads N coefficients from the poly RAM and
// reduces each one mod Q. It packs four 14-bit values per 56-bit group and streams the group out as 7 bytes.
module poly_tobytes #(
  parameter int N      = 512,
  parameter int Q      = 12289,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [15:0]       ram_dout,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready
);

  localparam int GROUPS = N / 4;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  localparam logic [15:0] Q1 = 16'(Q);
  localparam logic [15:0] Q2 = 16'(2 * Q);
  localparam logic [15:0] Q3 = 16'(3 * Q);
  localparam logic [15:0] Q4 = 16'(4 * Q);
  localparam logic [15:0] Q5 = 16'(5 * Q);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EMIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Handshake: a byte transfers on a cycle with byte_valid && byte_ready; while byte_ready is low
  // byte_out and byte_valid hold, and byte_valid never drops before its byte has been accepted.

  state_t            state_q;
  logic [GW-1:0]     g_q;
  logic [2:0]        cnt_q;
  logic [55:0]       w_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              byte_valid_q;
  logic              busy_q;
  logic              done_q;

  logic [15:0]       red_d;
  logic [ADDR_W-1:0] next_base_d;

  // Full reduction of any 16-bit value: at most five subtractions of Q are needed.
  always_comb begin
    red_d = ram_dout;
    if (ram_dout >= Q5)      red_d = ram_dout - Q5;
    else if (ram_dout >= Q4) red_d = ram_dout - Q4;
    else if (ram_dout >= Q3) red_d = ram_dout - Q3;
    else if (ram_dout >= Q2) red_d = ram_dout - Q2;
    else if (ram_dout >= Q1) red_d = ram_dout - Q1;
  end

  assign next_base_d = ADDR_W'(32'(g_q) * 4 + 4);

  // w_q doubles as the fetch accumulator (shifting in from the top) and the emit shift register
  // (shifting out from the bottom), so it is always empty when a new group starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      g_q          <= '0;
      cnt_q        <= '0;
      w_q          <= '0;
      ram_addr_q   <= '0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= FETCH;
            busy_q     <= 1'b1;
            g_q        <= '0;
            cnt_q      <= '0;
            ram_addr_q <= '0;
          end
        end
        FETCH: begin
          if (cnt_q < 3'd3) ram_addr_q <= ram_addr_q + 1'b1;
          // Read data lags the address by one cycle, so captures happen in fetch cycles 1..4.
          if (cnt_q != 3'd0) w_q <= {red_d[13:0], w_q[55:14]};
          if (cnt_q == 3'd4) begin
            state_q      <= EMIT;
            byte_valid_q <= 1'b1;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        EMIT: begin
          if (byte_ready) begin
            w_q <= w_q >> 8;
            if (cnt_q == 3'd6) begin
              byte_valid_q <= 1'b0;
              cnt_q        <= '0;
              if (g_q == GW'(GROUPS - 1)) begin
                state_q <= FINISH;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                g_q        <= g_q + 1'b1;
                ram_addr_q <= next_base_d;
                state_q    <= FETCH;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          g_q     <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done       = done_q;
  assign busy       = busy_q;
  assign ram_addr   = ram_addr_q;
  assign byte_out   = w_q[7:0];
  assign byte_valid = byte_valid_q;

endmodule

// File: tb/tb_poly_tobytes.sv
// Bench for poly_tobytes: a RAM model, a byte scoreboard fed from a packing model, and table vectors
// for the first group. It also runs sequences for back-pressure, a start while busy and a mid-stream reset.
module tb_poly_tobytes;

  localparam int N      = 512;
  localparam int Q      = 12289;
  localparam int ADDR_W = 9;
  localparam int NBYTES = 7 * N / 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              done;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_dout = '0;
  logic [7:0]        byte_out;
  logic              byte_valid;
  logic              byte_ready;

  logic [15:0] mem [N];
  logic [7:0]  exp_q[$];
  logic [7:0]  cap_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int busy_gap = 0;
  int acc_base, done_base, gap_base, cap_base;
  bit run_active = 1'b0;
  bit prev_stall = 1'b0;

  typedef struct packed {
    logic [1:0]       fill;
    logic [3:0][15:0] c;
    logic [6:0][7:0]  b;
  } vec_t;

  vec_t vecs [4];

  poly_tobytes #(.N(N), .Q(Q), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .done       (done),
    .busy       (busy),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready)
  );

  // Clock and synchronous-read RAM model.
  always #5 clk = ~clk;
  always @(posedge clk) ram_dout <= mem[ram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: every accepted byte is popped and compared; stalls must hold the expected byte.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (run_active && !busy && !done && done_cnt == done_base) busy_gap++;
      if (!busy) chk("valid_while_idle", {31'd0, byte_valid}, 32'd0);
      if (prev_stall) chk("stall_valid", {31'd0, byte_valid}, 32'd1);
      if (byte_valid && !byte_ready && exp_q.size() > 0)
        chk("stall_byte", {24'd0, byte_out}, {24'd0, exp_q[0]});
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_byte: got 0x%0h with nothing expected at %0t", byte_out, $time);
        end else begin
          chk("byte", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
        end
        cap_q.push_back(byte_out);
        acc_cnt++;
      end
      prev_stall = byte_valid && !byte_ready;
    end
  end

  task automatic load_mem(input logic [1:0] fill, input logic [3:0][15:0] c);
    for (int i = 0; i < N; i++) begin
      case (fill)
        2'd0:    mem[i] = 16'd0;
        2'd1:    mem[i] = 16'd12288;
        default: mem[i] = 16'($urandom_range(0, 65535));
      endcase
    end
    for (int k = 0; k < 4; k++) mem[k] = c[k];
  endtask

  // Packing model: reduce with %, lay t0..t3 into 14-bit fields, queue bytes little-endian.
  task automatic build_exp();
    logic [55:0] w;
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    for (int g = 0; g < N / 4; g++) begin
      for (int k = 0; k < 4; k++) w[14*k +: 14] = 14'(int'(mem[4*g+k]) % Q);
      for (int b = 0; b < 7; b++) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic prep();
    acc_base  = acc_cnt;
    done_base = done_cnt;
    gap_base  = busy_gap;
    cap_base  = cap_q.size();
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    run_active = 1'b1;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (acc_cnt - acc_base < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("wait_acc_reached", {31'd0, (acc_cnt - acc_base >= target)}, 32'd1);
  endtask

  task automatic finish_run();
    int n = 0;
    while (done_cnt == done_base && n < 4000) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    run_active = 1'b0;
    chk("byte_total", acc_cnt - acc_base, NBYTES);
    chk("done_pulses", done_cnt - done_base, 1);
    chk("exp_left", exp_q.size(), 0);
    chk("busy_gap", busy_gap - gap_base, 0);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0].fill = 2'd0;
    vecs[0].c    = {16'd0, 16'd0, 16'd0, 16'd0};
    vecs[0].b    = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1].fill = 2'd2;
    vecs[1].c    = {16'd4, 16'd3, 16'd2, 16'd1};
    vecs[1].b    = {8'h00, 8'h10, 8'h00, 8'h30, 8'h00, 8'h80, 8'h01};
    vecs[2].fill = 2'd1;
    vecs[2].c    = {16'd12288, 16'd12288, 16'd12288, 16'd12288};
    vecs[2].b    = {8'hC0, 8'h03, 8'h00, 8'h0C, 8'h00, 8'h30, 8'h00};
    vecs[3].fill = 2'd2;
    vecs[3].c    = {16'd65535, 16'd24578, 16'd12290, 16'd12289};
    vecs[3].b    = {8'h3F, 8'hE8, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00};

    rst = 1'b1; start = 1'b0; byte_ready = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_byte", {24'd0, byte_out}, 32'd0);
    chk("rst_addr", {23'd0, ram_addr}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Table vectors: full stream checked by the scoreboard, first group against the table.
    for (int i = 0; i < 4; i++) begin
      load_mem(vecs[i].fill, vecs[i].c);
      build_exp();
      prep();
      do_start();
      finish_run();
      for (int j = 0; j < 7; j++) begin
        if (cap_q.size() > cap_base + j)
          chk($sformatf("vec%0d_byte%0d", i, j), {24'd0, cap_q[cap_base+j]}, {24'd0, vecs[i].b[j]});
        else
          chk($sformatf("vec%0d_byte%0d_missing", i, j), cap_q.size(), cap_base + j + 1);
      end
    end

    // Back-pressure after byte 3 of group 5, then a start pulse while busy.
    load_mem(2'd2, {16'd1000, 16'd40000, 16'd65535, 16'd12289});
    build_exp();
    prep();
    do_start();
    wait_acc(5 * 7 + 4, 2000);
    #1 byte_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, byte_valid}, 32'd1);
      if (exp_q.size() > 0) chk("bp_hold_byte", {24'd0, byte_out}, {24'd0, exp_q[0]});
    end
    @(posedge clk); #1 byte_ready = 1'b1;
    wait_acc(100, 2000);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_run();

    // Reset during group 40: abort with no done, then a fresh full stream.
    load_mem(2'd2, {16'd7, 16'd6, 16'd5, 16'd4});
    build_exp();
    prep();
    do_start();
    wait_acc(40 * 7 + 3, 2000);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    run_active = 1'b0;
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    chk("midrst_valid", {31'd0, byte_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_addr", {23'd0, ram_addr}, 32'd0);
    repeat (30) @(posedge clk);
    chk("midrst_no_done", done_cnt - done_base, 0);

    load_mem(2'd2, {16'd65535, 16'd0, 16'd12288, 16'd36867});
    build_exp();
    prep();
    do_start();
    finish_run();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/poly_tobytes.md
Name: poly_tobytes

Overview:
- Serialiser stage directly downstream of the polynomial arithmetic unit.
- After an arithmetic pass completes, it reads all N coefficients from the shared poly RAM and fully reduces each one mod Q.
- It packs each reduced coefficient into 14 bits and streams the packed polynomial out as bytes over a valid/ready handshake.
- The packing is the NewHope poly_tobytes encoding: 512 coefficients give 896 bytes.

Parameters:
- N, 512, number of coefficients per polynomial.
- Q, 12289, modulus.
- ADDR_W, 9, poly RAM address width (2^ADDR_W >= N).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; begins serialisation of the polynomial
- done  output  1  one-cycle pulse after the last byte is accepted
- busy  output  1  high from the cycle after an accepted start until done
- ram_addr  output  ADDR_W  poly RAM read address
- ram_dout  input  16  poly RAM read data; synchronous read, valid 1 cycle after ram_addr
- byte_out  output  8  packed output byte
- byte_valid  output  1  byte_out holds a valid byte
- byte_ready  input  1  downstream accepts byte_out this cycle

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: done=0, busy=0, byte_valid=0, byte_out=0, ram_addr=0, FSM=IDLE, group counter=0.
- Reset mid-operation: abort immediately, return to IDLE, no done pulse, partially packed data discarded.
- Reduction (combinational on ram_dout, v in 0..65535): r = v - k*Q, where k is the largest value in 0..5 with k*Q <= v. Result r is in 0..Q-1 and stored as 14 bits.
- Packing:
  - Coefficients are grouped 4 at a time: t0..t3 = coeff[4g..4g+3], g = 0..N/4-1.
  - Form the 56-bit word W = {t3,t2,t1,t0}.
  - Emit W little-endian as 7 bytes, W[7:0] first through W[55:48].
  - Total bytes per polynomial = 7*N/4.
- FSM states:
  - IDLE: wait for start. start while not IDLE is ignored.
  - FETCH:
    - Drive ram_addr = 4g+k for k = 0..3 on consecutive cycles.
    - Capture the reduced ram_dout one cycle after each address into slot k.
    - The 4th capture occurs in the 5th FETCH cycle, then go to EMIT.
    - FETCH latency is 5 cycles per group.
  - EMIT:
    - byte_valid=1 with byte_out = byte j of W, j = 0..6.
    - j advances only on the cycle byte_valid && byte_ready.
    - While byte_ready=0, byte_out and byte_valid hold stable.
    - After byte 6 is accepted: if g = N/4-1, go to FINISH; otherwise g++ and go to FETCH.
    - byte_valid drops to 0 in the cycle after the last accept of a group.
  - FINISH: done=1 for exactly one cycle, busy=0, g=0, go to IDLE.
- byte_valid never asserts outside EMIT, and never drops before its byte is accepted.
- Throughput with byte_ready held at 1: 12 cycles per group (5 fetch + 7 emit), 1536 cycles for N=512 plus start and finish overhead.
- The block does not write the RAM. The RAM port must not be shared with the arithmetic unit while busy=1; the controller guarantees this.

Test Plan:
- All 512 coefficients 0, byte_ready=1 -> exactly 896 bytes of 0x00, then done pulses once; busy high throughout.
- coeff[0..3] = 1,2,3,4 -> first 7 bytes 0x01,0x80,0x00,0x30,0x00,0x10,0x00.
- All coefficients 12288 -> each group emits 0x00,0x30,0x00,0x0C,0x00,0x03,0xC0.
- Reduction boundaries, coeff[0..3] = 12289, 12290, 24578, 65535 -> reduced values 0, 1, 0, 4090. Check the 56-bit group word: first byte 0x00, second byte 0x40.
- Back-pressure: drop byte_ready for 10 cycles after byte 3 of group 5 -> byte_out and byte_valid stable for all 10 cycles. No byte lost or duplicated; total still 896.
- Robustness:
  - Assert rst during group 40 -> next cycle byte_valid=0, busy=0, done never pulses.
  - A fresh start then produces a full 896-byte stream.
  - A second start asserted while busy is ignored.
